// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and line/beat geometry for the cache-to-memory burst arbiter
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/line_beat_shifter.sv
// line_beat_shifter: beat counter and line register that splits/assembles a cache line into memory beats
module line_beat_shifter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              step,
    input  logic              capture,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] merged,
    output logic [BEAT_W-1:0] beat_out,
    output logic              last
);
    logic [$clog2(BEATS)-1:0] beat;
    logic [LINE_W-1:0] line;
    always_comb begin
        merged = line;
        merged[BEAT_W*beat +: BEAT_W] = beat_in;
    end
    assign beat_out = line[BEAT_W*beat +: BEAT_W];
    assign last = &beat;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
            line <= '0;
        end else if (load) begin
            beat <= '0;
            line <= load_line;
        end else if (step) begin
            beat <= beat + 1'b1;
            if (capture) line <= merged;
        end
    end
endmodule

// File: rtl/line_burst_arbiter.sv
// line_burst_arbiter: round-robin arbitration of icache/dcache line transfers onto a 4-beat burst memory port
module line_burst_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    arb_state_t state, state_d;
    grant_t grant, grant_d, last_grant, last_d;
    logic rd_d, wr_d, iresp_d, dresp_d, load, step, capture, last, d_pick;
    logic [ADDR_W-1:0] addr_d, req_addr;
    logic [LINE_W-1:0] merged;
    logic [BEAT_W-1:0] beat_out;

    line_beat_shifter u_shifter (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_line(d_wdata),
        .step(step),
        .capture(capture),
        .beat_in(mem_rdata),
        .merged(merged),
        .beat_out(beat_out),
        .last(last)
    );

    assign mem_wdata = mem_write ? beat_out : '0;

    always_comb begin
        d_pick = (d_read || d_write) && (!i_read || last_grant == GRANT_I);
        req_addr = d_pick ? d_addr : i_addr;
        state_d = state;
        grant_d = grant;
        last_d = last_grant;
        rd_d = mem_read;
        wr_d = mem_write;
        addr_d = mem_addr;
        iresp_d = 1'b0;
        dresp_d = 1'b0;
        load = 1'b0;
        step = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (i_read || d_read || d_write) begin
                load = 1'b1;
                grant_d = d_pick ? GRANT_D : GRANT_I;
                last_d = grant_d;
                addr_d = {req_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                wr_d = d_pick && d_write;
                rd_d = !wr_d;
                state_d = wr_d ? WR_BURST : RD_BURST;
            end
            RD_BURST: if (mem_resp) begin
                step = 1'b1;
                capture = 1'b1;
                if (last) begin
                    rd_d = 1'b0;
                    iresp_d = grant == GRANT_I;
                    dresp_d = grant == GRANT_D;
                    state_d = DONE;
                end
            end
            WR_BURST: if (mem_resp) begin
                step = 1'b1;
                if (last) begin
                    wr_d = 1'b0;
                    dresp_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= GRANT_I;
            last_grant <= GRANT_I;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            last_grant <= last_d;
            mem_read <= rd_d;
            mem_write <= wr_d;
            mem_addr <= addr_d;
            i_resp <= iresp_d;
            d_resp <= dresp_d;
            if (iresp_d) i_rdata <= merged;
            if (dresp_d && mem_read) d_rdata <= merged;
        end
    end
endmodule
